// File: rtl/oct_scan_cnt_if.sv
// Control/display bundle for oct_scan_cnt. Port `up` exists only when CNT_DOWN_EN is defined.
interface oct_scan_cnt_if;
  logic       btn;
  logic       clr;
`ifdef CNT_DOWN_EN
  logic       up;
`endif
  logic [2:0] dig0;
  logic [2:0] dig1;
  logic [2:0] dig2;
  logic [2:0] dig3;
  logic [1:0] clk_ctl;
  logic       running;
  logic       wrap;

  modport master (
    output btn, clr,
`ifdef CNT_DOWN_EN
    output up,
`endif
    input  dig0, dig1, dig2, dig3, clk_ctl, running, wrap
  );

  modport slave (
    input  btn, clr,
`ifdef CNT_DOWN_EN
    input  up,
`endif
    output dig0, dig1, dig2, dig3, clk_ctl, running, wrap
  );
endinterface

// File: rtl/oct_scan_cnt.sv
// Four-digit octal start/stop counter with prescaled tick and free-running digit-scan select.
// Optional down-counting is enabled by defining macro CNT_DOWN_EN.
module oct_scan_cnt #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned SCAN_W   = 18
) (
  input logic           clk,
  input logic           rst_n,
  oct_scan_cnt_if.slave bus
);
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {STOP, RUN} state_t;

  state_t            state, state_nxt;
  logic [SCAN_W-1:0] scan;
  logic [PW-1:0]     presc;
  logic [11:0]       cnt;
  logic [11:0]       cnt_nxt;
  logic              carry;
  logic              wrap_q;
  logic              btn_q;
  logic              armed;
  logic              btn_rise;
  logic              tick;
  logic              dir_up;

  assign tick = (presc == PW'(TICK_DIV - 1));

  // armed stays low until btn has been seen low, so a button held through reset never toggles
  assign btn_rise = bus.btn & ~btn_q & armed;

`ifdef CNT_DOWN_EN
  assign dir_up = bus.up;
`else
  assign dir_up = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan  <= '0;
      presc <= '0;
      btn_q <= 1'b0;
      armed <= 1'b0;
      state <= STOP;
    end else begin
      scan  <= scan + SCAN_W'(1);
      btn_q <= bus.btn;
      armed <= armed | ~bus.btn;
      state <= state_nxt;
      if (bus.clr || tick) presc <= '0;
      else                 presc <= presc + PW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    if (btn_rise) state_nxt = (state == RUN) ? STOP : RUN;
  end

  // Packed 3-bit digits form a plain binary word, so octal carry/borrow is ordinary +/-1;
  // the 13th bit is the overflow/underflow out of the top digit.
  always_comb begin
    cnt_nxt = cnt;
    carry   = 1'b0;
    if (dir_up) {carry, cnt_nxt} = {1'b0, cnt} + 13'd1;
    else        {carry, cnt_nxt} = {1'b0, cnt} - 13'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      wrap_q <= 1'b0;
    end else if (bus.clr) begin
      cnt    <= '0;
      wrap_q <= 1'b0;
    end else if (tick && state == RUN) begin
      cnt    <= cnt_nxt;
      wrap_q <= carry;
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign bus.dig0    = cnt[11:9];
  assign bus.dig1    = cnt[8:6];
  assign bus.dig2    = cnt[5:3];
  assign bus.dig3    = cnt[2:0];
  assign bus.clk_ctl = scan[SCAN_W-1:SCAN_W-2];
  assign bus.running = (state == RUN);
  assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_oct_scan_cnt.sv
// Directed self-checking bench for oct_scan_cnt with TICK_DIV=4, SCAN_W=4.
module tb_oct_scan_cnt;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int unsigned checks   = 0;
  int unsigned failures = 0;

  oct_scan_cnt_if bus();

  oct_scan_cnt #(.TICK_DIV(4), .SCAN_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] digs();
    return {bus.dig0, bus.dig1, bus.dig2, bus.dig3};
  endfunction

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Every tick lands on each 4th edge after reset release while the bench stays aligned.
  task automatic run_ticks(input int unsigned n);
    step(4 * n);
  endtask

  initial begin
    int unsigned wraps;
    int unsigned moved;

    bus.btn = 1'b0;
    bus.clr = 1'b0;
`ifdef CNT_DOWN_EN
    bus.up  = 1'b1;
`endif

    // reset state
    step(3);
    chk("rst_digits",  32'(digs()),       32'h0);
    chk("rst_running", 32'(bus.running),  32'h0);
    chk("rst_wrap",    32'(bus.wrap),     32'h0);
    chk("rst_clk_ctl", 32'(bus.clk_ctl),  32'h0);

    // idle: scan select steps every 4 clk, digits hold at zero
    rst_n = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (i % 4 == 0) chk("clk_ctl", 32'(bus.clk_ctl), 32'((i / 4) % 4));
    end
    chk("idle_digits",  32'(digs()),      32'h0);
    chk("idle_running", 32'(bus.running), 32'h0);

    // start and count 0..7 then carry into dig2
    bus.btn = 1'b1;
    step(1);
    bus.btn = 1'b0;
    chk("start_running", 32'(bus.running), 32'h1);
    step(3);
    chk("count_1", 32'(digs()), 32'h1);
    for (int n = 2; n <= 8; n++) begin
      run_ticks(1);
      chk("count_n", 32'(digs()), 32'(n));
    end
    chk("carry_dig2", 32'(bus.dig2), 32'h1);
    chk("carry_dig3", 32'(bus.dig3), 32'h0);

    // long run up to 7776, then 7777, then wrap to 0000
    wraps = 0;
    for (int i = 0; i < 4086 * 4; i++) begin
      step(1);
      if (bus.wrap) wraps++;
    end
    chk("no_early_wrap", 32'(wraps), 32'h0);
    chk("at_7776", 32'(digs()), 32'(12'o7776));
    run_ticks(1);
    chk("at_7777",      32'(digs()),   32'(12'o7777));
    chk("wrap_low_7777", 32'(bus.wrap), 32'h0);
    run_ticks(1);
    chk("up_wrap_digits", 32'(digs()),   32'h0);
    chk("up_wrap_pulse",  32'(bus.wrap), 32'h1);
    step(1);
    chk("wrap_one_cycle", 32'(bus.wrap), 32'h0);
    step(3);
    chk("after_wrap", 32'(digs()), 32'h1);

`ifdef CNT_DOWN_EN
    bus.up = 1'b0;
    run_ticks(1);
    chk("down_to_0",      32'(digs()),   32'h0);
    chk("down_no_wrap",   32'(bus.wrap), 32'h0);
    run_ticks(1);
    chk("down_wrap_dig",  32'(digs()),   32'(12'o7777));
    chk("down_wrap_pulse", 32'(bus.wrap), 32'h1);
    bus.up = 1'b1;
    run_ticks(65);
    chk("at_0100", 32'(digs()), 32'(12'o0100));
    bus.up = 1'b0;
    run_ticks(1);
    chk("borrow_0077",  32'(digs()),   32'(12'o0077));
    chk("borrow_nowrap", 32'(bus.wrap), 32'h0);
    bus.up = 1'b1;
`endif

    // clear on a tick cycle, then count to 5 and clear on a tick again
    step(3);
    bus.clr = 1'b1;
    step(1);
    bus.clr = 1'b0;
    chk("clr0_digits", 32'(digs()), 32'h0);
    run_ticks(5);
    chk("at_0005", 32'(digs()), 32'h5);
    step(3);
    chk("pre_clr", 32'(digs()), 32'h5);
    bus.clr = 1'b1;
    step(1);
    bus.clr = 1'b0;
    chk("clr_digits",  32'(digs()),      32'h0);
    chk("clr_no_wrap", 32'(bus.wrap),    32'h0);
    chk("clr_keeps_run", 32'(bus.running), 32'h1);

    // stop press coinciding with a tick: tick still applies under RUN
    run_ticks(3);
    chk("at_0003", 32'(digs()), 32'h3);
    step(3);
    bus.btn = 1'b1;
    step(1);
    bus.btn = 1'b0;
    chk("tick_on_toggle", 32'(digs()),      32'h4);
    chk("stopped",        32'(bus.running), 32'h0);
    moved = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (digs() != 12'h4 || bus.wrap) moved++;
    end
    chk("frozen", 32'(moved), 32'h0);

    // restart, reach 0123, then async reset between edges
    bus.btn = 1'b1;
    step(1);
    bus.btn = 1'b0;
    chk("restart", 32'(bus.running), 32'h1);
    step(3);
    chk("restart_5", 32'(digs()), 32'h5);
    run_ticks(78);
    chk("at_0123", 32'(digs()), 32'(12'o0123));
    step(1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_digits",  32'(digs()),      32'h0);
    chk("arst_clk_ctl", 32'(bus.clk_ctl), 32'h0);
    chk("arst_running", 32'(bus.running), 32'h0);
    chk("arst_wrap",    32'(bus.wrap),    32'h0);

    // release with btn held high: no toggle until a fresh press
    bus.btn = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step(8);
    chk("held_btn_running", 32'(bus.running), 32'h0);
    chk("held_btn_digits",  32'(digs()),      32'h0);
    bus.btn = 1'b0;
    step(1);
    bus.btn = 1'b1;
    step(1);
    bus.btn = 1'b0;
    chk("rearm_running", 32'(bus.running), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/oct_scan_cnt.md
OCT_SCAN_CNT -- requirements
Module: oct_scan_cnt

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100000000, clk cycles per count tick (>=2).
REQ-002 The block SHALL have parameter SCAN_W, default 18, width of the free-running scan counter (>=2).
REQ-003 The block SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port btn  input  1  debounced start/stop level; a rising edge toggles run state.
REQ-006 The block SHALL have port clr  input  1  synchronous clear of digits and prescaler.
REQ-007 The block SHALL have port up  input  1  count direction, 1 = up, 0 = down; present only with CNT_DOWN_EN.
REQ-008 The block SHALL have ports dig0..dig3  output  3 each  octal digits, dig0 most significant, dig3 least significant, registered.
REQ-009 The block SHALL have port clk_ctl  output  2  digit-scan select = scan counter bits [SCAN_W-1:SCAN_W-2].
REQ-010 The block SHALL have port running  output  1  high in state RUN.
REQ-011 The block SHALL have port wrap  output  1  one-cycle pulse on a full-count wrap.

Function
REQ-012 The scan counter SHALL increment every clk, wrap modulo 2^SCAN_W, and ignore btn, clr and run state.
REQ-013 The prescaler SHALL count 0..TICK_DIV-1 and wrap; tick is internal, high for one cycle when prescaler = TICK_DIV-1.
REQ-014 The FSM SHALL have states STOP and RUN; a btn rising edge (registered btn 0 -> current btn 1) toggles the state on the next clk edge.
REQ-015 The digits SHALL change only on a tick while the state is RUN. In STOP, digits hold.
REQ-016 An up-count SHALL increment dig3; when a digit is 7 and receives a carry, it becomes 0 and carries into the next more-significant digit.
REQ-017 Up-count at 7777 SHALL give 0000 and assert wrap for exactly that cycle.
REQ-018 A down-count SHALL decrement with borrow; 0000 becomes 7777 with wrap asserted for one cycle.
REQ-019 clr SHALL zero the digits and prescaler next edge, take priority over tick, and leave the FSM state unchanged; no wrap SHALL be generated on clr.
REQ-020 If a btn edge and a tick coincide, the tick SHALL be applied per the pre-toggle state.
REQ-021 Latency SHALL be: digits update on the clk edge at which tick is high; wrap is asserted in that same cycle as the updated digits.

Reset
REQ-022 While rst_n = 0, the block SHALL force, independent of clk: digits 0, prescaler 0, scan counter 0 (clk_ctl = 00), state STOP, running 0, wrap 0, btn edge register 0.
REQ-023 Reset deasserted mid-count SHALL restart from zero with no spurious wrap or toggle, even if btn is held high.

Configuration
REQ-024 With macro CNT_DOWN_EN defined, port up SHALL exist and the direction SHALL follow REQ-016/REQ-018, sampled on the tick cycle.
REQ-025 Without CNT_DOWN_EN, port up SHALL be absent and the block SHALL count up only; REQ-018 does not apply.

Verification (TICK_DIV=4, SCAN_W=4)
REQ-026 The bench SHALL cover: reset released, btn=0 for 40 clk -> digits 0000, running 0, clk_ctl steps 00,01,10,11 every 4 clk.
REQ-027 The bench SHALL cover: btn pulse, then 32 clk -> running 1, dig3 advances once per 4 clk to 0..7, then dig2=1, dig3=0.
REQ-028 The bench SHALL cover: digits 7776 in RUN, up=1 -> next tick 7777, following tick 0000 with wrap high one cycle.
REQ-029 The bench SHALL cover: CNT_DOWN_EN, up=0 at 0000 -> tick gives 7777 and wrap; 0100 -> tick gives 0077.
REQ-030 The bench SHALL cover: clr asserted on a tick cycle at 0005 -> 0000 and no wrap; second btn pulse -> STOP and digits frozen over 20 clk.
REQ-031 The bench SHALL cover: rst_n low asynchronously mid-RUN at 0123 -> all outputs zero immediately, with no clk edge required.
